leitor_teclado: RTL and testbench

//  Matrix keypad scanner for the vending-machine front panel; input-side counterpart of the display multiplexer.

---
 rtl/teclado_pkg.sv | 23 ++
 rtl/leitor_teclado_if.sv | 11 +
 rtl/sincronizador_2ff.sv | 19 +
 rtl/leitor_teclado.sv | 121 ++++++++++++
 tb/tb_leitor_teclado.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/teclado_pkg.sv
// teclado_pkg: shared constants, FSM/scan-class encodings and column helpers
// for the keypad scanner.
package teclado_pkg;
   localparam int ROWS  = 4;
   localparam int COLS  = 4;
   localparam int KEY_W = 4;
   localparam int CB    = $clog2(COLS);
   typedef enum logic [1:0] {SOLTO, DEB_PRESS, PRESSIONADO} estado_t;
   typedef enum logic [1:0] {VAZIO, UNICO, MULTIPLO} classe_t;
   // Key count in one row sample, saturated at 2 (meaning "more than one").
   function automatic logic [1:0] conta_teclas(input logic [COLS-1:0] p);
      logic [2:0] n;
      n = 3'($countones(p));
      return (n > 3'd1) ? 2'd2 : n[1:0];
   endfunction
   function automatic logic [CB-1:0] coluna(input logic [COLS-1:0] p);
      logic [CB-1:0] c;
      c = '0;
      for (int i = COLS - 1; i >= 0; i--)
         if (p[i]) c = CB'(i);
      return c;
   endfunction
endpackage

// File: rtl/leitor_teclado_if.sv
// leitor_teclado_if: key code valid/ack handshake between the keypad scanner
// (master) and the control FSM (slave).
interface leitor_teclado_if;
   import teclado_pkg::*;
   logic [KEY_W-1:0] key_code;
   logic             key_valid;
   logic             key_ack;
   logic             key_overrun;
   modport master (output key_code, output key_valid, output key_overrun, input key_ack);
   modport slave  (input key_code, input key_valid, input key_overrun, output key_ack);
endinterface

// File: rtl/sincronizador_2ff.sv
// sincronizador_2ff: two-flop synchronizer for idle-high asynchronous lines.
module sincronizador_2ff #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] meta;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         meta <= '1;
         q    <= '1;
      end else begin
         meta <= d;
         q    <= meta;
      end
endmodule

// File: rtl/leitor_teclado.sv
// leitor_teclado: 4x4 matrix keypad scanner with per-scan debounce, one code per
// press delivered over a valid/ack handshake with overrun flag.
module leitor_teclado
   import teclado_pkg::*;
#(
   parameter int SCAN_DIV       = 1000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [COLS-1:0] cols_in,
   output logic [ROWS-1:0] rows_out,
   leitor_teclado_if.master kb
);
   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
   localparam int RW = $clog2(ROWS);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_SCANS);

   logic [DW-1:0]    dwell;
   logic [RW-1:0]    row;
   logic [COLS-1:0]  cols_s, press;
   logic [1:0]       acc_n, row_n, tot_n;
   logic [2:0]       soma;
   logic [KEY_W-1:0] acc_code, row_code, scan_code, cand;
   logic [CW-1:0]    cnt;
   logic             amostra, fim_varredura, aceita;
   estado_t          estado;
   classe_t          classe;

   sincronizador_2ff #(.WIDTH(COLS)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (cols_in),
      .q     (cols_s)
   );

   assign rows_out      = ~(ROWS'(1) << row);
   assign press         = ~cols_s;
   assign amostra       = dwell == DWELL_LAST;
   assign fim_varredura = amostra && row == RW'(ROWS - 1);
   assign row_n         = conta_teclas(press);
   assign row_code      = {row, coluna(press)};
   assign soma          = 3'(acc_n) + 3'(row_n);
   assign tot_n         = (soma > 3'd1) ? 2'd2 : soma[1:0];
   // With a single key in the scan it sits either in this row or in the accumulator.
   assign scan_code     = (row_n == 2'd1) ? row_code : acc_code;
   assign classe        = (tot_n == 2'd0) ? VAZIO : (tot_n == 2'd1) ? UNICO : MULTIPLO;
   assign aceita        = fim_varredura && classe == UNICO &&
                          ((estado == SOLTO && DEBOUNCE_SCANS == 1) ||
                           (estado == DEB_PRESS && scan_code == cand && cnt == CNT_MAX - 1'b1));

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         dwell          <= '0;
         row            <= '0;
         acc_n          <= '0;
         acc_code       <= '0;
         kb.key_code    <= '0;
         kb.key_valid   <= 1'b0;
         kb.key_overrun <= 1'b0;
      end else begin
         dwell <= amostra ? '0 : dwell + 1'b1;
         if (amostra) begin
            row      <= row + 1'b1;
            acc_n    <= fim_varredura ? 2'd0 : tot_n;
            acc_code <= fim_varredura ? '0 : scan_code;
         end
         kb.key_overrun <= aceita && kb.key_valid && !kb.key_ack;
         if (aceita) begin
            kb.key_code  <= scan_code;
            kb.key_valid <= 1'b1;
         end else if (kb.key_ack) begin
            kb.key_valid <= 1'b0;
         end
      end

   // Debounce FSM; advances only when a full matrix scan completes.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         estado <= SOLTO;
         cnt    <= '0;
         cand   <= '0;
      end else if (fim_varredura) begin
         case (estado)
            SOLTO:
               if (classe == UNICO) begin
                  cand   <= scan_code;
                  cnt    <= aceita ? '0 : CW'(1);
                  estado <= aceita ? PRESSIONADO : DEB_PRESS;
               end
            DEB_PRESS:
               if (classe != UNICO) begin
                  estado <= SOLTO;
                  cnt    <= '0;
               end else if (scan_code != cand) begin
                  cand <= scan_code;
                  cnt  <= CW'(1);
               end else if (aceita) begin
                  estado <= PRESSIONADO;
                  cnt    <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            PRESSIONADO:
               if (classe != VAZIO) begin
                  cnt <= '0;
               end else if (cnt == CNT_MAX - 1'b1) begin
                  estado <= SOLTO;
                  cnt    <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            default: begin
               estado <= SOLTO;
               cnt    <= '0;
            end
         endcase
      end
endmodule

// File: tb/tb_leitor_teclado.sv
// tb_leitor_teclado: keypad scanner bench with a physical keypad model and a
// scan-level press/release model checked against the DUT every cycle.
module tb_leitor_teclado;
   localparam int D = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [3:0]  cols_in;
   logic [3:0]  rows_out;
   logic [15:0] pressed = '0;

   int checks = 0, passed = 0;
   int p = 0, run = 0, quiet = 0, rises = 0, ovr = 0;
   bit armed = 1'b1, ev = 1'b0, eo = 1'b0, pv = 1'b0;
   logic [3:0] last = '0, ec = '0;

   leitor_teclado_if kb ();

   leitor_teclado #(.SCAN_DIV(4), .DEBOUNCE_SCANS(D)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cols_in  (cols_in),
      .rows_out (rows_out),
      .kb       (kb)
   );

   always #5 clk = ~clk;

   // Keypad: a pressed key shorts its column to its row while that row is driven low.
   always_comb begin
      cols_in = '1;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !rows_out[r]) cols_in[c] = 1'b0;
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   function automatic logic [3:0] exp_rows(input int pos);
      logic [3:0] r;
      r = ~(4'b0001 << ((pos / 4) % 4));
      return r;
   endfunction

   // Scan-level model: a key is reported after D identical single-key scans while armed;
   // it re-arms only after D consecutive empty scans.
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         p = 0; run = 0; quiet = 0; armed = 1'b1;
         last = '0; ev = 1'b0; ec = '0; eo = 1'b0;
      end else begin
         bit acc;
         int n;
         logic [3:0] code;
         p++;
         acc = 1'b0;
         eo = 1'b0;
         if (p % 16 == 0) begin
            n = $countones(pressed);
            code = '0;
            for (int i = 0; i < 16; i++) if (pressed[i]) code = 4'(i);
            if (armed) begin
               if (n == 1) begin
                  run = (run > 0 && code == last) ? run + 1 : 1;
                  last = code;
                  if (run == D) begin acc = 1'b1; armed = 1'b0; quiet = 0; run = 0; end
               end else run = 0;
            end else begin
               quiet = (n == 0) ? quiet + 1 : 0;
               if (quiet == D) begin armed = 1'b1; run = 0; end
            end
         end
         if (acc) begin
            eo = ev && !kb.key_ack;
            ev = 1'b1;
            ec = last;
         end else if (kb.key_ack) ev = 1'b0;
      end

   always @(negedge clk) begin
      if (kb.key_valid && !pv) rises++;
      if (kb.key_overrun) ovr++;
      pv = kb.key_valid;
      if (rst_n) begin
         chk("rows_out", rows_out, exp_rows(p));
         chk("key_valid", kb.key_valid, ev);
         chk("key_overrun", kb.key_overrun, eo);
         if (ev) chk("key_code", kb.key_code, ec);
      end
   end

   task automatic hold(input logic [15:0] m, input int n);
      int k = 0;
      pressed = m;
      while (k < n) begin
         @(posedge clk); #1;
         if (p % 16 == 0) k++;
      end
   endtask

   task automatic ack_seq();
      repeat (2) @(posedge clk);
      #1 kb.key_ack = 1'b1;
      @(posedge clk);
      #1 kb.key_ack = 1'b0;
      @(negedge clk); #1;
      chk("ack_clears_valid", kb.key_valid, 0);
   endtask

   task automatic reset_pulse(input string nm);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk({nm, "_rows"}, rows_out, 4'b1110);
      chk({nm, "_valid"}, kb.key_valid, 0);
      chk({nm, "_code"}, kb.key_code, 0);
      chk({nm, "_overrun"}, kb.key_overrun, 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      kb.key_ack = 1'b0;
      #2 reset_pulse("reset");
      hold(16'h0000, 10);
      chk("idle_valid", kb.key_valid, 0);
      hold(16'h0200, 5);
      chk("k9_code", kb.key_code, 9);
      chk("k9_valid", kb.key_valid, 1);
      chk("k9_once", rises, 1);
      hold(16'h0000, 2);
      hold(16'h0020, 2);
      fork
         hold(16'h0000, 2);
         begin
            @(negedge clk); #1;
            chk("k5_code", kb.key_code, 5);
            chk("k5_valid", kb.key_valid, 1);
            chk("k5_overrun", ovr, 1);
            chk("k5_no_rise", rises, 1);
            ack_seq();
            @(posedge clk);
            #1 kb.key_ack = 1'b1;
            @(posedge clk);
            #1 kb.key_ack = 1'b0;
            @(negedge clk); #1;
            chk("idle_ack_valid", kb.key_valid, 0);
            chk("idle_ack_code", kb.key_code, 5);
         end
      join
      hold(16'h0001, 1);
      hold(16'h0000, 2);
      hold(16'h1001, 3);
      hold(16'h0000, 2);
      chk("bounce_multi_valid", kb.key_valid, 0);
      chk("bounce_multi_rises", rises, 1);
      hold(16'h0040, 2);
      chk("k6_code", kb.key_code, 6);
      chk("k6_valid", kb.key_valid, 1);
      hold(16'h0000, 2);
      fork
         hold(16'h0008, 2);
         begin
            repeat (31) @(posedge clk);
            #1 kb.key_ack = 1'b1;
            @(posedge clk);
            #1 kb.key_ack = 1'b0;
         end
      join
      fork
         hold(16'h0000, 2);
         begin
            @(negedge clk); #1;
            chk("ack_accept_valid", kb.key_valid, 1);
            chk("ack_accept_code", kb.key_code, 3);
            chk("ack_accept_overrun", ovr, 1);
            ack_seq();
         end
      join
      hold(16'h0200, 1);
      repeat (5) @(posedge clk);
      reset_pulse("rst_deb");
      hold(16'h0400, 1);
      chk("fresh_1scan_valid", kb.key_valid, 0);
      hold(16'h0400, 1);
      @(negedge clk); #1;
      chk("fresh_2scan_valid", kb.key_valid, 1);
      chk("fresh_2scan_code", kb.key_code, 10);
      reset_pulse("rst_valid");
      hold(16'h0400, 2);
      @(negedge clk); #1;
      chk("after_rst_valid", kb.key_valid, 1);
      chk("after_rst_code", kb.key_code, 10);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
